// File: rtl/riscv_mem_pkg.sv
// Shared types for the data-RAM arbitration path.
// Owner encoding and statistics counter width.
package riscv_mem_pkg;

  typedef enum logic {
    OWN_CORE,
    OWN_HOST
  } arb_owner_e;

  localparam int RAM_ARB_STAT_W = 16;

endpackage

// File: rtl/ram_arb_starve_ctr.sv
// Saturating host starvation counter (wait_cnt).
// at_max flags that the host has waited MAX_WAIT cycles.
module ram_arb_starve_ctr
  import riscv_mem_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clear,
  input  logic inc,
  output logic at_max
);

  localparam int W = $clog2(MAX_WAIT + 1);
  localparam logic [W-1:0] MAX_V = W'(MAX_WAIT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == MAX_V);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Core/host arbiter for the single-port data RAM; core has priority.
// Define RAM_ARB_STATS_EN to add grant/stall statistics outputs.
module ram_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32,
  parameter int MAX_WAIT   = 8
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [ADDR_WIDTH-1:0] CORE_ADDR,
  input  logic                  CORE_WE,
  input  logic                  CORE_RE,
  input  logic [SIZE-1:0]       CORE_WDATA,
  output logic [SIZE-1:0]       CORE_RDATA,
  output logic                  CORE_STALL,
  input  logic                  HOST_REQ,
  input  logic                  HOST_WE,
  input  logic [ADDR_WIDTH-1:0] HOST_ADDR,
  input  logic [SIZE-1:0]       HOST_WDATA,
  output logic                  HOST_GNT,
  output logic                  HOST_RVALID,
  output logic [SIZE-1:0]       HOST_RDATA,
`ifdef RAM_ARB_STATS_EN
  output logic [RAM_ARB_STAT_W-1:0] STAT_HOST_GNTS,
  output logic [RAM_ARB_STAT_W-1:0] STAT_CORE_STALLS,
`endif
  output logic [ADDR_WIDTH-1:0] ADDR_RAM,
  output logic                  ENABLE_W,
  output logic [SIZE-1:0]       Q_W,
  input  logic [SIZE-1:0]       Q_RAM
);

  logic       core_act;
  logic       at_max;
  logic       gnt;
  arb_owner_e owner;

  logic            rvalid_q;
  logic [SIZE-1:0] rdata_q;

  assign core_act = CORE_WE | CORE_RE;
  // Reset gating keeps the RAM and host quiet while RESET_N is low
  assign gnt      = RESET_N & HOST_REQ & (~core_act | at_max);
  assign owner    = gnt ? OWN_HOST : OWN_CORE;

  assign HOST_GNT    = gnt;
  assign CORE_STALL  = gnt & core_act;
  assign CORE_RDATA  = Q_RAM;
  assign HOST_RVALID = rvalid_q;
  assign HOST_RDATA  = rdata_q;

  ram_arb_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .clear  (~HOST_REQ | gnt),
    .inc    (HOST_REQ & ~gnt),
    .at_max (at_max)
  );

  always_comb begin
    ADDR_RAM = CORE_ADDR;
    Q_W      = CORE_WDATA;
    ENABLE_W = 1'b0;
    unique case (owner)
      OWN_HOST: begin
        ADDR_RAM = HOST_ADDR;
        Q_W      = HOST_WDATA;
        ENABLE_W = HOST_WE;
      end
      OWN_CORE: begin
        ENABLE_W = CORE_WE & RESET_N;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= gnt & ~HOST_WE;
      if (gnt && !HOST_WE) begin
        rdata_q <= Q_RAM;
      end
    end
  end

`ifdef RAM_ARB_STATS_EN
  logic [RAM_ARB_STAT_W-1:0] gnts_q;
  logic [RAM_ARB_STAT_W-1:0] stalls_q;

  assign STAT_HOST_GNTS   = gnts_q;
  assign STAT_CORE_STALLS = stalls_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      gnts_q   <= '0;
      stalls_q <= '0;
    end else begin
      if (gnt && gnts_q != '1) begin
        gnts_q <= gnts_q + 1'b1;
      end
      if (CORE_STALL && stalls_q != '1) begin
        stalls_q <= stalls_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter.
// Includes a behavioural RAM with combinational read.
module tb_ram_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic [AW-1:0] CORE_ADDR;
  logic          CORE_WE;
  logic          CORE_RE;
  logic [DW-1:0] CORE_WDATA;
  logic [DW-1:0] CORE_RDATA;
  logic          CORE_STALL;
  logic          HOST_REQ;
  logic          HOST_WE;
  logic [AW-1:0] HOST_ADDR;
  logic [DW-1:0] HOST_WDATA;
  logic          HOST_GNT;
  logic          HOST_RVALID;
  logic [DW-1:0] HOST_RDATA;
  logic [AW-1:0] ADDR_RAM;
  logic          ENABLE_W;
  logic [DW-1:0] Q_W;
  logic [DW-1:0] Q_RAM;
`ifdef RAM_ARB_STATS_EN
  logic [15:0]   STAT_HOST_GNTS;
  logic [15:0]   STAT_CORE_STALLS;
`endif

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [1024];

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (ENABLE_W) mem[ADDR_RAM] <= Q_W;
  end
  assign Q_RAM = mem[ADDR_RAM];

  ram_arbiter #(
    .ADDR_WIDTH(AW),
    .SIZE      (DW),
    .MAX_WAIT  (8)
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .CORE_ADDR  (CORE_ADDR),
    .CORE_WE    (CORE_WE),
    .CORE_RE    (CORE_RE),
    .CORE_WDATA (CORE_WDATA),
    .CORE_RDATA (CORE_RDATA),
    .CORE_STALL (CORE_STALL),
    .HOST_REQ   (HOST_REQ),
    .HOST_WE    (HOST_WE),
    .HOST_ADDR  (HOST_ADDR),
    .HOST_WDATA (HOST_WDATA),
    .HOST_GNT   (HOST_GNT),
    .HOST_RVALID(HOST_RVALID),
    .HOST_RDATA (HOST_RDATA),
`ifdef RAM_ARB_STATS_EN
    .STAT_HOST_GNTS  (STAT_HOST_GNTS),
    .STAT_CORE_STALLS(STAT_CORE_STALLS),
`endif
    .ADDR_RAM   (ADDR_RAM),
    .ENABLE_W   (ENABLE_W),
    .Q_W        (Q_W),
    .Q_RAM      (Q_RAM)
  );

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_all();
    CORE_WE  = 1'b0;
    CORE_RE  = 1'b0;
    HOST_REQ = 1'b0;
    HOST_WE  = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    RESET_N    = 1'b0;
    CORE_ADDR  = 10'd7;
    CORE_WE    = 1'b1;
    CORE_RE    = 1'b0;
    CORE_WDATA = 32'h1234_5678;
    HOST_REQ   = 1'b1;
    HOST_WE    = 1'b1;
    HOST_ADDR  = 10'd1;
    HOST_WDATA = 32'h0;
    tick();
    tick();
    #2;
    checks++;
    if (HOST_GNT !== 1'b0 || CORE_STALL !== 1'b0) begin
      failures++;
      $display("FAIL rst_gnt gnt=%b stall=%b want 0",
               HOST_GNT, CORE_STALL);
    end
    checks++;
    if (ENABLE_W !== 1'b0 || ADDR_RAM !== 10'd7) begin
      failures++;
      $display("FAIL rst_ram we=%b addr=%0d want 0/7",
               ENABLE_W, ADDR_RAM);
    end
    checks++;
    if (HOST_RVALID !== 1'b0 || HOST_RDATA !== 32'h0) begin
      failures++;
      $display("FAIL rst_rd rv=%b rd=%h want 0/0",
               HOST_RVALID, HOST_RDATA);
    end
    idle_all();
    tick();
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_idle_write();
    HOST_REQ   = 1'b1;
    HOST_WE    = 1'b1;
    HOST_ADDR  = 10'd5;
    HOST_WDATA = 32'hDEAD_BEEF;
    #2;
    checks++;
    if (HOST_GNT !== 1'b1 || CORE_STALL !== 1'b0) begin
      failures++;
      $display("FAIL iw_gnt gnt=%b stall=%b want 1/0",
               HOST_GNT, CORE_STALL);
    end
    checks++;
    if (ENABLE_W !== 1'b1 || ADDR_RAM !== 10'd5 ||
        Q_W !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL iw_ram we=%b a=%0d d=%h want 1/5/deadbeef",
               ENABLE_W, ADDR_RAM, Q_W);
    end
    tick();
    HOST_REQ  = 1'b0;
    CORE_RE   = 1'b1;
    CORE_ADDR = 10'd5;
    #2;
    checks++;
    if (CORE_RDATA !== 32'hDEAD_BEEF || HOST_RVALID !== 1'b0) begin
      failures++;
      $display("FAIL iw_load rd=%h rv=%b want deadbeef/0",
               CORE_RDATA, HOST_RVALID);
    end
    tick();
    idle_all();
  endtask

  task automatic test_host_read();
    HOST_REQ  = 1'b1;
    HOST_WE   = 1'b0;
    HOST_ADDR = 10'd5;
    #2;
    checks++;
    if (HOST_GNT !== 1'b1 || ENABLE_W !== 1'b0 ||
        HOST_RVALID !== 1'b0) begin
      failures++;
      $display("FAIL hr_gnt gnt=%b we=%b rv=%b want 1/0/0",
               HOST_GNT, ENABLE_W, HOST_RVALID);
    end
    tick();
    HOST_REQ = 1'b0;
    #2;
    checks++;
    if (HOST_RVALID !== 1'b1 || HOST_RDATA !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL hr_data rv=%b rd=%h want 1/deadbeef",
               HOST_RVALID, HOST_RDATA);
    end
    tick();
    #2;
    checks++;
    if (HOST_RVALID !== 1'b0 || HOST_RDATA !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL hr_hold rv=%b rd=%h want 0/deadbeef",
               HOST_RVALID, HOST_RDATA);
    end
    tick();
  endtask

  task automatic test_starvation();
    CORE_RE   = 1'b1;
    CORE_ADDR = 10'd9;
    HOST_REQ  = 1'b1;
    HOST_WE   = 1'b0;
    HOST_ADDR = 10'd5;
    for (int i = 0; i < 8; i++) begin
      #2;
      checks++;
      if (HOST_GNT !== 1'b0 || CORE_STALL !== 1'b0 ||
          ADDR_RAM !== 10'd9) begin
        failures++;
        $display("FAIL sv_wait%0d gnt=%b stall=%b a=%0d want 0/0/9",
                 i, HOST_GNT, CORE_STALL, ADDR_RAM);
      end
      tick();
    end
    #2;
    checks++;
    if (HOST_GNT !== 1'b1 || CORE_STALL !== 1'b1 ||
        ADDR_RAM !== 10'd5) begin
      failures++;
      $display("FAIL sv_force gnt=%b stall=%b a=%0d want 1/1/5",
               HOST_GNT, CORE_STALL, ADDR_RAM);
    end
    tick();
    #2;
    checks++;
    if (HOST_GNT !== 1'b0 || CORE_STALL !== 1'b0 ||
        ADDR_RAM !== 10'd9 || HOST_RVALID !== 1'b1 ||
        HOST_RDATA !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL sv_after gnt=%b st=%b a=%0d rv=%b rd=%h",
               HOST_GNT, CORE_STALL, ADDR_RAM,
               HOST_RVALID, HOST_RDATA);
    end
    idle_all();
    tick();
  endtask

  task automatic test_simul_write();
    CORE_WE    = 1'b1;
    CORE_ADDR  = 10'd3;
    CORE_WDATA = 32'h1111_1111;
    HOST_REQ   = 1'b1;
    HOST_WE    = 1'b1;
    HOST_ADDR  = 10'd3;
    HOST_WDATA = 32'h2222_2222;
    #2;
    checks++;
    if (HOST_GNT !== 1'b0 || ENABLE_W !== 1'b1 ||
        Q_W !== 32'h1111_1111) begin
      failures++;
      $display("FAIL sw_core gnt=%b we=%b d=%h want 0/1/11111111",
               HOST_GNT, ENABLE_W, Q_W);
    end
    tick();
    for (int i = 1; i < 8; i++) begin
      #2;
      checks++;
      if (HOST_GNT !== 1'b0) begin
        failures++;
        $display("FAIL sw_wait%0d gnt=%b want 0", i, HOST_GNT);
      end
      tick();
    end
    #2;
    checks++;
    if (HOST_GNT !== 1'b1 || ENABLE_W !== 1'b1 ||
        Q_W !== 32'h2222_2222) begin
      failures++;
      $display("FAIL sw_host gnt=%b we=%b d=%h want 1/1/22222222",
               HOST_GNT, ENABLE_W, Q_W);
    end
    tick();
    idle_all();
    CORE_RE = 1'b1;
    #2;
    checks++;
    if (CORE_RDATA !== 32'h2222_2222) begin
      failures++;
      $display("FAIL sw_load rd=%h want 22222222", CORE_RDATA);
    end
    tick();
    idle_all();
  endtask

  task automatic test_abort();
    CORE_RE   = 1'b1;
    CORE_ADDR = 10'd9;
    HOST_REQ  = 1'b1;
    HOST_WE   = 1'b0;
    HOST_ADDR = 10'd5;
    for (int i = 0; i < 4; i++) begin
      #2;
      checks++;
      if (HOST_GNT !== 1'b0) begin
        failures++;
        $display("FAIL ab_pre%0d gnt=%b want 0", i, HOST_GNT);
      end
      tick();
    end
    HOST_REQ = 1'b0;
    tick();
    HOST_REQ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #2;
      checks++;
      if (HOST_GNT !== 1'b0) begin
        failures++;
        $display("FAIL ab_wait%0d gnt=%b want 0", i, HOST_GNT);
      end
      tick();
    end
    #2;
    checks++;
    if (HOST_GNT !== 1'b1 || CORE_STALL !== 1'b1) begin
      failures++;
      $display("FAIL ab_force gnt=%b stall=%b want 1/1",
               HOST_GNT, CORE_STALL);
    end
    tick();
    idle_all();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp [2];
    exp[0] = 32'hA5A5_0010;
    exp[1] = 32'h5A5A_0011;
    for (int i = 0; i < 2; i++) begin
      HOST_REQ   = 1'b1;
      HOST_WE    = 1'b1;
      HOST_ADDR  = AW'(10 + i);
      HOST_WDATA = exp[i];
      #2;
      checks++;
      if (HOST_GNT !== 1'b1 || ENABLE_W !== 1'b1) begin
        failures++;
        $display("FAIL bb_wr%0d gnt=%b we=%b want 1/1",
                 i, HOST_GNT, ENABLE_W);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      HOST_REQ  = (i < 2);
      HOST_WE   = 1'b0;
      HOST_ADDR = AW'(10 + (i % 2));
      #2;
      if (i > 0) begin
        checks++;
        if (HOST_RVALID !== 1'b1 || HOST_RDATA !== exp[i-1]) begin
          failures++;
          $display("FAIL bb_rd%0d rv=%b rd=%h want 1/%h",
                   i - 1, HOST_RVALID, HOST_RDATA, exp[i-1]);
        end
      end
      tick();
    end
    idle_all();
    tick();
  endtask

  task automatic test_reset_mid_read();
    HOST_REQ  = 1'b1;
    HOST_WE   = 1'b0;
    HOST_ADDR = 10'd10;
    CORE_ADDR = 10'd4;
    #2;
    checks++;
    if (HOST_GNT !== 1'b1) begin
      failures++;
      $display("FAIL rm_gnt gnt=%b want 1", HOST_GNT);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if (HOST_GNT !== 1'b0 || ADDR_RAM !== 10'd4 ||
        HOST_RDATA !== 32'h0) begin
      failures++;
      $display("FAIL rm_async gnt=%b a=%0d rd=%h want 0/4/0",
               HOST_GNT, ADDR_RAM, HOST_RDATA);
    end
    tick();
    #2;
    checks++;
    if (HOST_RVALID !== 1'b0 || HOST_RDATA !== 32'h0 ||
        ENABLE_W !== 1'b0 || CORE_STALL !== 1'b0) begin
      failures++;
      $display("FAIL rm_post rv=%b rd=%h we=%b st=%b want 0",
               HOST_RVALID, HOST_RDATA, ENABLE_W, CORE_STALL);
    end
`ifdef RAM_ARB_STATS_EN
    checks++;
    if (STAT_HOST_GNTS !== 16'h0 || STAT_CORE_STALLS !== 16'h0) begin
      failures++;
      $display("FAIL rm_stats g=%0d s=%0d want 0/0",
               STAT_HOST_GNTS, STAT_CORE_STALLS);
    end
`endif
    idle_all();
    RESET_N = 1'b1;
    tick();
    #2;
    checks++;
    if (HOST_RVALID !== 1'b0) begin
      failures++;
      $display("FAIL rm_norv rv=%b want 0", HOST_RVALID);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_idle_write();
    test_host_read();
    test_starvation();
    test_simul_write();
    test_abort();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
